// File: rtl/dsi_pkg.sv
// Shared MIPI DSI definitions: data types, sync byte, header ECC and payload CRC helpers.
// Used by both the byte packetizer and the byte depacketizer.
package dsi_pkg;

  localparam logic [5:0] DT_VSS    = 6'h01;
  localparam logic [5:0] DT_HSS    = 6'h21;
  localparam logic [5:0] DT_EOTP   = 6'h08;
  localparam logic [5:0] DT_RGB888 = 6'h3E;
  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_HDR     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CRC     = 3'd4,
    ST_SKIP    = 3'd5
  } rx_state_e;

  // Each parity bit covers the header bits selected by its row mask.
  function automatic logic [5:0] dsi_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ 16'h8408;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  function automatic logic is_long_dt(input logic [5:0] dt);
    logic long_pkt;
    case (dt[3:0])
      4'h9, 4'hC, 4'hD, 4'hE: long_pkt = 1'b1;
      default:                long_pkt = 1'b0;
    endcase
    return long_pkt;
  endfunction

endpackage

// File: rtl/dsi_rx_crc16.sv
// Running CRC-16/CCITT accumulator over payload bytes, with clear and enable.
module dsi_rx_crc16
  import dsi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] crc_r;

  // Accumulator: restart on clear, fold in one byte per enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_r <= 16'hFFFF;
    end else if (clr) begin
      crc_r <= 16'hFFFF;
    end else if (en) begin
      crc_r <= crc16_byte(crc_r, data);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/dsi_byte_depacketizer.sv
// Single-lane DSI byte receiver: header parse/ECC check, sync decode, RGB888 unpack.
// Payload checksum verification is built only when DSI_RX_CRC_CHECK_EN is defined.
module dsi_byte_depacketizer
  import dsi_pkg::*;
#(
  parameter logic [1:0] VC         = 2'd0,
  parameter logic [5:0] DT         = 6'h3E,
  parameter int         word_width = 24
) (
  input  logic                  byte_clk,
  input  logic                  reset_n,
  input  logic                  hs_active,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_D0,
  output logic                  vsync,
  output logic                  hsync,
  output logic                  eotp,
  output logic                  pix_de,
  output logic [word_width-1:0] pix_data,
  output logic [5:0]            pkt_dt,
  output logic [15:0]           pkt_wc,
  output logic                  ecc_err,
  output logic                  crc_err,
  output logic                  pkt_abort
);

  rx_state_e             state_r;
  logic [1:0]            hdr_idx_r;
  logic [7:0]            di_r, wc_lo_r, wc_hi_r;
  logic [15:0]           remain_r;
  logic                  pix_pkt_r;
  logic [1:0]            rgb_idx_r;
  logic [7:0]            red_r, green_r;
  logic                  crc_idx_r;
  logic                  vsync_r, hsync_r, eotp_r, pix_de_r, ecc_err_r, pkt_abort_r;
  logic [word_width-1:0] pix_data_r;
  logic [5:0]            pkt_dt_r;
  logic [15:0]           pkt_wc_r;

  logic [15:0] wc_s;
  logic        ecc_ok_s;
  logic        vc_ok_s;

  assign wc_s     = {wc_hi_r, wc_lo_r};
  assign ecc_ok_s = (byte_D0 == {2'b00, dsi_ecc({wc_hi_r, wc_lo_r, di_r})});
  assign vc_ok_s  = (di_r[7:6] == VC);

  // Receive FSM: header parsing, payload unpacking and all registered pulses
  always_ff @(posedge byte_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      hdr_idx_r   <= 2'd0;
      di_r        <= 8'd0;
      wc_lo_r     <= 8'd0;
      wc_hi_r     <= 8'd0;
      remain_r    <= 16'd0;
      pix_pkt_r   <= 1'b0;
      rgb_idx_r   <= 2'd0;
      red_r       <= 8'd0;
      green_r     <= 8'd0;
      crc_idx_r   <= 1'b0;
      vsync_r     <= 1'b0;
      hsync_r     <= 1'b0;
      eotp_r      <= 1'b0;
      pix_de_r    <= 1'b0;
      ecc_err_r   <= 1'b0;
      pkt_abort_r <= 1'b0;
      pix_data_r  <= '0;
      pkt_dt_r    <= 6'd0;
      pkt_wc_r    <= 16'd0;
    end else begin
      vsync_r     <= 1'b0;
      hsync_r     <= 1'b0;
      eotp_r      <= 1'b0;
      pix_de_r    <= 1'b0;
      ecc_err_r   <= 1'b0;
      pkt_abort_r <= 1'b0;
      if (!hs_active) begin
        // A lane dropping out of HS beats any byte presented in the same cycle.
        pkt_abort_r <= (state_r == ST_HDR) || (state_r == ST_PAYLOAD) || (state_r == ST_CRC);
        state_r     <= ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: state_r <= ST_SYNC;
          ST_SYNC: begin
            if (byte_valid) begin
              hdr_idx_r <= 2'd0;
              state_r   <= (byte_D0 == SYNC_BYTE) ? ST_HDR : ST_SKIP;
            end
          end
          ST_HDR: begin
            if (byte_valid) begin
              hdr_idx_r <= hdr_idx_r + 2'd1;
              case (hdr_idx_r)
                2'd0: di_r    <= byte_D0;
                2'd1: wc_lo_r <= byte_D0;
                2'd2: wc_hi_r <= byte_D0;
                default: begin
                  if (!ecc_ok_s) begin
                    ecc_err_r <= 1'b1;
                    state_r   <= ST_SKIP;
                  end else begin
                    pkt_dt_r <= di_r[5:0];
                    pkt_wc_r <= wc_s;
                    if (is_long_dt(di_r[5:0])) begin
                      remain_r  <= wc_s;
                      rgb_idx_r <= 2'd0;
                      crc_idx_r <= 1'b0;
                      pix_pkt_r <= vc_ok_s && (di_r[5:0] == DT);
                      state_r   <= (wc_s == 16'd0) ? ST_CRC : ST_PAYLOAD;
                    end else begin
                      vsync_r <= vc_ok_s && (di_r[5:0] == DT_VSS);
                      hsync_r <= vc_ok_s && (di_r[5:0] == DT_HSS);
                      eotp_r  <= vc_ok_s && (di_r[5:0] == DT_EOTP);
                    end
                  end
                end
              endcase
            end
          end
          ST_PAYLOAD: begin
            if (byte_valid) begin
              remain_r <= remain_r - 16'd1;
              if (remain_r == 16'd1) begin
                state_r <= ST_CRC;
              end
              if (pix_pkt_r) begin
                case (rgb_idx_r)
                  2'd0: begin
                    red_r     <= byte_D0;
                    rgb_idx_r <= 2'd1;
                  end
                  2'd1: begin
                    green_r   <= byte_D0;
                    rgb_idx_r <= 2'd2;
                  end
                  default: begin
                    pix_data_r <= {red_r, green_r, byte_D0};
                    pix_de_r   <= 1'b1;
                    rgb_idx_r  <= 2'd0;
                  end
                endcase
              end
            end
          end
          ST_CRC: begin
            if (byte_valid) begin
              crc_idx_r <= ~crc_idx_r;
              if (crc_idx_r) begin
                state_r <= ST_HDR;
              end
            end
          end
          ST_SKIP: state_r <= ST_SKIP;
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef DSI_RX_CRC_CHECK_EN
  logic        crc_clr_s, crc_en_s, crc_byte_s;
  logic [15:0] crc_acc_s;
  logic [7:0]  crc_lo_r;
  logic        crc_err_r;

  // Accumulator control: restart on every header ECC byte, fold in payload bytes
  always_comb begin
    crc_clr_s  = 1'b0;
    crc_en_s   = 1'b0;
    crc_byte_s = 1'b0;
    if (hs_active && byte_valid) begin
      crc_clr_s  = (state_r == ST_HDR) && (hdr_idx_r == 2'd3);
      crc_en_s   = (state_r == ST_PAYLOAD);
      crc_byte_s = (state_r == ST_CRC);
    end else begin
      crc_clr_s  = 1'b0;
      crc_en_s   = 1'b0;
      crc_byte_s = 1'b0;
    end
  end

  dsi_rx_crc16 u_crc (
    .clk   (byte_clk),
    .rst_n (reset_n),
    .clr   (crc_clr_s),
    .en    (crc_en_s),
    .data  (byte_D0),
    .crc   (crc_acc_s)
  );

  // Checksum capture (LSB first) and compare on the MSB byte
  always_ff @(posedge byte_clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_lo_r  <= 8'd0;
      crc_err_r <= 1'b0;
    end else begin
      crc_err_r <= 1'b0;
      if (crc_byte_s && !crc_idx_r) begin
        crc_lo_r <= byte_D0;
      end else if (crc_byte_s) begin
        crc_err_r <= ({byte_D0, crc_lo_r} != crc_acc_s);
      end else begin
        crc_lo_r <= crc_lo_r;
      end
    end
  end

  assign crc_err = crc_err_r;
`else
  assign crc_err = 1'b0;
`endif

  assign vsync     = vsync_r;
  assign hsync     = hsync_r;
  assign eotp      = eotp_r;
  assign pix_de    = pix_de_r;
  assign pix_data  = pix_data_r;
  assign pkt_dt    = pkt_dt_r;
  assign pkt_wc    = pkt_wc_r;
  assign ecc_err   = ecc_err_r;
  assign pkt_abort = pkt_abort_r;

endmodule

// File: tb/tb_dsi_byte_depacketizer.sv
// Scoreboard bench for dsi_byte_depacketizer: directed bursts then random bursts against a packet-level model.
`timescale 1ns/1ps
module tb_dsi_byte_depacketizer;

  logic        byte_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        hs_active = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_D0 = 8'h00;
  logic        vsync, hsync, eotp, pix_de, ecc_err, crc_err, pkt_abort;
  logic [23:0] pix_data;
  logic [5:0]  pkt_dt;
  logic [15:0] pkt_wc;

  dsi_byte_depacketizer #(.VC(2'd0), .DT(6'h3E), .word_width(24)) dut (
    .byte_clk(byte_clk), .reset_n(reset_n), .hs_active(hs_active),
    .byte_valid(byte_valid), .byte_D0(byte_D0),
    .vsync(vsync), .hsync(hsync), .eotp(eotp), .pix_de(pix_de), .pix_data(pix_data),
    .pkt_dt(pkt_dt), .pkt_wc(pkt_wc), .ecc_err(ecc_err), .crc_err(crc_err),
    .pkt_abort(pkt_abort)
  );

  always #5 byte_clk = ~byte_clk;

  localparam int K_VSYNC = 0, K_HSYNC = 1, K_EOTP = 2, K_PIX = 3, K_ECC = 4, K_CRC = 5, K_ABORT = 6;

  // Syndrome column of each header bit (bit 0 first).
  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  typedef struct { int kind; logic [31:0] data; } ev_t;
  ev_t         exp_q[$];
  logic [7:0]  burst[$];
  logic [7:0]  pl_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [5:0]  exp_dt = 6'd0;
  logic [15:0] exp_wc = 16'd0;

  function automatic logic [5:0] ref_ecc(input logic [23:0] d);
    logic [5:0] s;
    s = 6'd0;
    for (int i = 0; i < 24; i++) if (d[i]) s = s ^ ECC_COL[i];
    return s;
  endfunction

  // Bit-serial CRC over burst[start +: len], bits in wire order.
  function automatic logic [15:0] ref_crc(input int start, input int len);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int k = start; k < start + len; k++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ burst[k][b];
        c = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  function automatic logic ref_long(input logic [5:0] dt);
    return dt[3:0] inside {4'h9, 4'hC, 4'hD, 4'hE};
  endfunction

  task automatic push_ev(input int kind, input logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic put_hdr(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] eccx);
    burst.push_back(di);
    burst.push_back(wc[7:0]);
    burst.push_back(wc[15:8]);
    burst.push_back({2'b00, ref_ecc({wc, di})} ^ eccx);
  endtask

  task automatic put_long(input logic [1:0] vc, input logic [5:0] dt, input logic [7:0] eccx,
                          input logic [15:0] crcx);
    logic [15:0] wc, c;
    int          start;
    wc = 16'(pl_q.size());
    put_hdr({vc, dt}, wc, eccx);
    start = burst.size();
    foreach (pl_q[k]) burst.push_back(pl_q[k]);
    c = ref_crc(start, pl_q.size()) ^ crcx;
    burst.push_back(c[7:0]);
    burst.push_back(c[15:8]);
    pl_q.delete();
  endtask

  // Packet-level reference: walk the first n bytes of the burst and list the expected pulses.
  task automatic model_burst(input int n);
    int          i, avail, wc_i;
    logic [7:0]  di;
    logic [15:0] wc;
    if (n == 0) return;
    if (burst[0] != 8'hB8) return;
    i = 1;
    forever begin
      if (n - i < 4) break;
      di = burst[i];
      wc = {burst[i+2], burst[i+1]};
      if (burst[i+3] != {2'b00, ref_ecc({wc, di})}) begin
        push_ev(K_ECC, 32'd0);
        return;
      end
      exp_dt = di[5:0];
      exp_wc = wc;
      i += 4;
      if (!ref_long(di[5:0])) begin
        if (di[7:6] == 2'd0) begin
          if (di[5:0] == 6'h01) push_ev(K_VSYNC, {10'd0, wc, di[5:0]});
          if (di[5:0] == 6'h21) push_ev(K_HSYNC, {10'd0, wc, di[5:0]});
          if (di[5:0] == 6'h08) push_ev(K_EOTP, {10'd0, wc, di[5:0]});
        end
        continue;
      end
      wc_i = int'(wc);
      avail = (n - i < wc_i) ? n - i : wc_i;
      if (di[7:6] == 2'd0 && di[5:0] == 6'h3E)
        for (int p = 0; p + 3 <= avail; p += 3)
          push_ev(K_PIX, {8'd0, burst[i+p], burst[i+p+1], burst[i+p+2]});
      i += avail;
      if (avail < wc_i) break;
      if (n - i < 2) break;
`ifdef DSI_RX_CRC_CHECK_EN
      if ({burst[i+1], burst[i]} != ref_crc(i - wc_i, wc_i)) push_ev(K_CRC, 32'd0);
`endif
      i += 2;
    end
    push_ev(K_ABORT, 32'd0);
  endtask

  task automatic drive_bytes(input int n, input int gap);
    int g;
    hs_active = 1'b1;
    repeat (2) @(posedge byte_clk);
    #1;
    for (int k = 0; k < n; k++) begin
      if (gap < 0) g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      else g = gap;
      repeat (g) begin
        @(posedge byte_clk);
        #1;
      end
      byte_D0 = burst[k];
      byte_valid = 1'b1;
      @(posedge byte_clk);
      #1;
      byte_valid = 1'b0;
      byte_D0 = 8'($urandom);
    end
  endtask

  task automatic run_burst(input int n, input int gap);
    model_burst(n);
    drive_bytes(n, gap);
    hs_active = 1'b0;
    repeat (4) @(posedge byte_clk);
    #1;
    check("pkt_dt", {26'd0, pkt_dt}, {26'd0, exp_dt});
    check("pkt_wc", {16'd0, pkt_wc}, {16'd0, exp_wc});
    check("missing_pulses", exp_q.size(), 0);
    exp_q.delete();
    burst.delete();
  endtask

  task automatic build_pix(input logic [7:0] eccx, input logic [15:0] crcx);
    burst.delete();
    burst.push_back(8'hB8);
    pl_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    put_long(2'd0, 6'h3E, eccx, crcx);
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  logic [6:0]  mon_hits;
  int          mon_kind;
  logic [31:0] mon_data;
  ev_t         mon_ev;
  always @(negedge byte_clk) begin
    if (reset_n) begin
      mon_hits = {pkt_abort, crc_err, ecc_err, pix_de, eotp, hsync, vsync};
      if (mon_hits != 7'd0) begin
        mon_kind = 0;
        for (int b = 0; b < 7; b++) if (mon_hits[b]) mon_kind = b;
        case (mon_kind)
          K_VSYNC, K_HSYNC, K_EOTP: mon_data = {10'd0, pkt_wc, pkt_dt};
          K_PIX:                    mon_data = {8'd0, pix_data};
          default:                  mon_data = 32'd0;
        endcase
        n_checks++;
        if ($countones(mon_hits) != 1) begin
          n_fail++;
          $display("FAIL pulse_overlap: got %b, required a single pulse", mon_hits);
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: got kind %0d data %h, required none", mon_kind, mon_data);
        end else begin
          mon_ev = exp_q.pop_front();
          if (mon_ev.kind != mon_kind || mon_ev.data != mon_data) begin
            n_fail++;
            $display("FAIL pulse: got kind %0d data %h, required kind %0d data %h",
                     mon_kind, mon_data, mon_ev.kind, mon_ev.data);
          end
        end
      end
    end
  end

  int          np, n;
  logic [1:0]  vc;
  logic [7:0]  eccx, one8;
  logic [15:0] crcx;

  initial begin
    repeat (3) @(negedge byte_clk);
    check("reset_outputs", {vsync, hsync, eotp, pix_de, ecc_err, crc_err, pkt_abort, pix_data},
          32'd0);
    check("reset_pkt", {10'd0, pkt_wc, pkt_dt}, 32'd0);
    @(posedge byte_clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge byte_clk);
    #1;

    // VSS short packet
    burst.push_back(8'hB8);
    put_hdr({2'd0, 6'h01}, 16'h0000, 8'h00);
    run_burst(burst.size(), 0);
    // Pixel packet, good CRC
    build_pix(8'h00, 16'h0000);
    run_burst(burst.size(), 0);
    // Corrupted ECC byte
    build_pix(8'h01, 16'h0000);
    run_burst(burst.size(), 0);
    // Corrupted CRC LSB
    build_pix(8'h00, 16'h0001);
    run_burst(burst.size(), 0);
    // Abort after 2 of 6 payload bytes, then a clean burst
    build_pix(8'h00, 16'h0000);
    run_burst(7, 0);
    build_pix(8'h00, 16'h0000);
    run_burst(burst.size(), 0);
    // HSS on a foreign virtual channel
    burst.push_back(8'hB8);
    put_hdr({2'd1, 6'h21}, 16'h0000, 8'h00);
    run_burst(burst.size(), 0);
    // Three-cycle gaps inside a pixel packet
    build_pix(8'h00, 16'h0000);
    run_burst(burst.size(), 3);

    // Reset asserted mid-payload
    burst.push_back(8'hB8);
    put_hdr({2'd0, 6'h01}, 16'h1234, 8'h00);
    pl_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    put_long(2'd0, 6'h3E, 8'h00, 16'h0000);
    push_ev(K_VSYNC, {10'd0, 16'h1234, 6'h01});
    drive_bytes(11, 0);
    reset_n = 1'b0;
    @(negedge byte_clk);
    check("midreset_outputs", {vsync, hsync, eotp, pix_de, ecc_err, crc_err, pkt_abort, pix_data},
          32'd0);
    check("midreset_pkt", {10'd0, pkt_wc, pkt_dt}, 32'd0);
    hs_active = 1'b0;
    @(posedge byte_clk);
    #1;
    reset_n = 1'b1;
    exp_dt = 6'd0;
    exp_wc = 16'd0;
    check("midreset_queue", exp_q.size(), 0);
    exp_q.delete();
    burst.delete();
    build_pix(8'h00, 16'h0000);
    run_burst(burst.size(), 0);

    // Random multi-packet bursts with gaps, corruption and truncation
    for (int t = 0; t < 40; t++) begin
      np = $urandom_range(1, 4);
      burst.push_back(($urandom_range(0, 14) == 0) ? 8'h9A : 8'hB8);
      for (int p = 0; p < np; p++) begin
        vc = ($urandom_range(0, 3) == 0) ? 2'd1 : 2'd0;
        one8 = 8'h01;
        eccx = ($urandom_range(0, 9) == 0) ? (one8 << $urandom_range(0, 7)) : 8'h00;
        crcx = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000;
        case ($urandom_range(0, 5))
          0: put_hdr({vc, 6'h01}, 16'($urandom), eccx);
          1: put_hdr({vc, 6'h21}, 16'($urandom), eccx);
          2: put_hdr({vc, 6'h08}, 16'($urandom), eccx);
          3: put_hdr({vc, 6'h05}, 16'($urandom), eccx);
          4: begin
            for (int k = $urandom_range(0, 10); k > 0; k--) pl_q.push_back(8'($urandom));
            put_long(vc, 6'h3E, eccx, crcx);
          end
          default: begin
            for (int k = $urandom_range(0, 5); k > 0; k--) pl_q.push_back(8'($urandom));
            put_long(vc, 6'h29, eccx, crcx);
          end
        endcase
      end
      n = burst.size();
      if ($urandom_range(0, 4) == 0) n = $urandom_range(0, burst.size() - 1);
      run_burst(n, -1);
    end

    repeat (10) @(posedge byte_clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
